fb_rect_fill: RTL and testbench
===============================

Name: fb_rect_fill

Overview:
- Framebuffer write-side engine: accepts rectangle-fill commands and streams single-colour pixel writes into the write port of the 24-bit × 64K dual-clock framebuffer RAM.
- Scanout reads that RAM at 280×192 logical resolution: pixel-doubled horizontally, line-doubled vertically.
- This block is the producer/writer counterpart of scanout; it runs in the CLOCK_50 domain and drives fb_d, fb_adr_w, fb_we and fb_w_clk.

Parameters:
FB_WIDTH, 280, logical pixels per line; row stride in words
FB_HEIGHT, 192, logical lines
ADDR_W, 16, framebuffer address width; must satisfy FB_WIDTH*FB_HEIGHT <= 2**ADDR_W
DATA_W, 24, pixel width, packed {R[23:16],G[15:8],B[7:0]}

Ports:
CLOCK_50  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine idle, command can be accepted
cmd_x  in  9  left column, 0-based
cmd_y  in  8  top row, 0-based
cmd_w  in  9  width in pixels
cmd_h  in  8  height in lines
cmd_color  in  DATA_W  fill colour
stall  in  1  hold writes this cycle, e.g. arbitration loss
busy  out  1  command in progress
done  out  1  one-cycle pulse on command completion
err  out  1  one-cycle pulse on command rejection (see Optional Feature)
fb_d  out  DATA_W  write data
fb_adr_w  out  ADDR_W  write address
fb_we  out  1  write enable
fb_w_clk  out  1  write clock, equal to CLOCK_50

Behaviour:
- While reset=0: cmd_ready=0, busy=0, done=0, err=0, fb_we=0, fb_adr_w=0, fb_d=0, FSM=IDLE. Reset mid-fill aborts the fill immediately; no done pulse.
- FSM states: IDLE, SETUP, FILL, FIN.
- IDLE: cmd_ready=1 starting the first clock after reset deasserts. Handshake is cmd_valid&cmd_ready at edge T. At that edge, latch all cmd_* fields, set cmd_ready=0 and busy=1, go to SETUP.
- SETUP (one cycle):
  - Compute clipped extents: cw = min(w, FB_WIDTH−x) and ch = min(h, FB_HEIGHT−y).
  - If x>=FB_WIDTH, y>=FB_HEIGHT, w=0 or h=0, the result is zero-area; go to FIN with no writes.
  - Otherwise set row_base = y*FB_WIDTH and go to FILL.
- FILL:
  - One write per non-stalled cycle, in raster order.
  - fb_adr_w = row_base + col, fb_d = colour, fb_we=1. All are registered, so the first fb_we=1 appears in the cycle after edge T+2.
  - col increments to x+cw−1, then wraps to x. At the wrap, row_base += FB_WIDTH; no multiply per row.
  - stall=1: fb_we=0 that cycle; col, row and address hold. No write is lost or duplicated.
  - After the write of the last pixel at (x+cw−1, y+ch−1), go to FIN.
- FIN (one cycle): done=1, busy=0, fb_we=0. cmd_ready=1 in the following cycle, back in IDLE.
- Throughput: cw*ch write cycles plus stalls; command-to-command overhead is 3 cycles.
- fb_adr_w never exceeds FB_WIDTH*FB_HEIGHT−1. Address arithmetic is done at ADDR_W+1 bits internally so that wrap is never silent.
- cmd_valid while busy is ignored and fields are not re-sampled. A command may be held on the bus and is accepted when cmd_ready rises.
- done and err are never asserted in the same cycle.

Optional Feature:
- Macro FB_RECT_FILL_CLIP_EN.
- Defined: out-of-bounds rectangles are clipped to the framebuffer as described under SETUP; err is tied to 0.
- Undefined: SETUP checks whether x+w>FB_WIDTH or y+h>FB_HEIGHT. If so, the command is rejected: no writes, err pulses for one cycle in place of done, then return to IDLE. Zero-area commands still complete with done and no writes.

Test Plan:
- Fill x=0,y=0,w=280,h=192, color=24'hFF0000 → 53760 writes to addresses 0..53759, each exactly once, all data FF0000; one done pulse; busy low afterwards.
- Fill x=10,y=5,w=3,h=2, color=24'h00FF00 → writes in order to addresses 1410,1411,1412,1690,1691,1692; first fb_we two cycles after handshake; done 1 cycle after last write.
- Same 3×2 command with stall asserted for writes 2 and 5 for 4 cycles each → identical address/data sequence, 6 writes total, fb_we=0 during stall.
- x=278,y=190,w=5,h=5:
  - CLIP_EN defined → 4 writes (53478,53479,53758,53759), then done.
  - CLIP_EN undefined → 0 writes, err pulse, no done.
- w=0 (any x, y) → no writes, done after SETUP; cmd_ready back within 3 cycles of the handshake.
- Reset asserted in the middle of a 100×100 fill → fb_we, busy and done go low asynchronously. After release, cmd_ready=1 on the next edge and a new 1×1 fill at (0,0) writes address 0 only.

Source files
------------

// File: rtl/fb_rect_fill.sv
// fb_rect_fill: rectangle-fill write engine for the 280x192 24-bit framebuffer.
// Latency: first fb_we two cycles after the handshake edge; done/err one cycle after the last write.
// Backpressure: stall freezes the raster walk with no write lost; cmd_ready is low from accept until back in IDLE.
//
// Ports: CLOCK_50/reset (async, active-low); cmd_valid/cmd_ready handshake with
// cmd_x/cmd_y/cmd_w/cmd_h/cmd_color; stall holds writes; busy/done/err status;
// fb_d/fb_adr_w/fb_we/fb_w_clk drive the framebuffer RAM write port.
// Optional macro FB_RECT_FILL_CLIP_EN: when defined, off-screen rectangles are
// clipped and err is tied low; when undefined, they are rejected with an err pulse.
module fb_rect_fill #(
  parameter int FB_WIDTH  = 280,
  parameter int FB_HEIGHT = 192,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 24
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [8:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [8:0]        cmd_w,
  input  logic [7:0]        cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] fb_d,
  output logic [ADDR_W-1:0] fb_adr_w,
  output logic              fb_we,
  output logic              fb_w_clk
);

  // One spare address bit so an overflow shows up instead of aliasing.
  localparam int AW1 = ADDR_W + 1;
  localparam logic [9:0]     W10    = 10'(FB_WIDTH);
  localparam logic [8:0]     H9     = 9'(FB_HEIGHT);
  localparam logic [AW1-1:0] STRIDE = AW1'(FB_WIDTH);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, FIN} state_t;
  state_t state, state_nxt;

  logic [8:0]        x_q, w_q;
  logic [7:0]        y_q, h_q;
  logic [DATA_W-1:0] color_q;
  logic [8:0]        col, col_end;
  logic [7:0]        row_left;
  logic [AW1-1:0]    row_base;

  logic [9:0]     x_ext, w_ext, room_x;
  logic [8:0]     y_ext, h_ext, room_y;
  logic [8:0]     cw;
  logic [7:0]     ch;
  logic           zero_area, go_fill, last_px;
  logic [AW1-1:0] wr_addr;
`ifndef FB_RECT_FILL_CLIP_EN
  logic           oob, rej_q;
`endif

  assign fb_w_clk = CLOCK_50;

  // Extents seen from SETUP; widened so x+w and y+h cannot overflow.
  always_comb begin
    x_ext     = {1'b0, x_q};
    w_ext     = {1'b0, w_q};
    y_ext     = {1'b0, y_q};
    h_ext     = {1'b0, h_q};
    room_x    = W10 - x_ext;  // meaningful only when x is on-screen
    room_y    = H9 - y_ext;
    cw        = 9'((w_ext < room_x) ? w_ext : room_x);
    ch        = 8'((h_ext < room_y) ? h_ext : room_y);
    zero_area = (x_ext >= W10) || (y_ext >= H9) || (w_q == '0) || (h_q == '0);
`ifdef FB_RECT_FILL_CLIP_EN
    go_fill   = !zero_area;
`else
    oob       = ((x_ext + w_ext) > W10) || ((y_ext + h_ext) > H9);
    go_fill   = !zero_area && !oob;
`endif
    last_px   = (col == col_end) && (row_left == '0);
    wr_addr   = row_base + AW1'(col);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid && cmd_ready) state_nxt = SETUP;
      SETUP:   state_nxt = go_fill ? FILL : FIN;
      FILL:    if (!stall && last_px) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outputs are registered, so they trail the state by one cycle: done shows
  // in the cycle after the last write, cmd_ready the cycle after that.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fb_we     <= 1'b0;
      fb_adr_w  <= '0;
      fb_d      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
      col       <= '0;
      col_end   <= '0;
      row_left  <= '0;
      row_base  <= '0;
`ifndef FB_RECT_FILL_CLIP_EN
      err       <= 1'b0;
      rej_q     <= 1'b0;
`endif
    end else begin
      fb_we <= 1'b0;
      done  <= 1'b0;
`ifndef FB_RECT_FILL_CLIP_EN
      err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            x_q       <= cmd_x;
            y_q       <= cmd_y;
            w_q       <= cmd_w;
            h_q       <= cmd_h;
            color_q   <= cmd_color;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        SETUP: begin
          col      <= x_q;
          col_end  <= x_q + cw - 9'd1;
          row_left <= ch - 8'd1;
          row_base <= AW1'(y_q) * STRIDE;  // the only multiply per command
`ifndef FB_RECT_FILL_CLIP_EN
          rej_q    <= !zero_area && oob;
`endif
        end
        FILL: begin
          if (!stall) begin
            // An address past the RAM is dropped rather than wrapped.
            fb_we    <= !wr_addr[ADDR_W];
            fb_adr_w <= wr_addr[ADDR_W-1:0];
            fb_d     <= color_q;
            if (col == col_end) begin
              col      <= x_q;
              row_base <= row_base + STRIDE;
              row_left <= row_left - 8'd1;
            end else begin
              col <= col + 9'd1;
            end
          end
        end
        FIN: begin
          busy <= 1'b0;
`ifdef FB_RECT_FILL_CLIP_EN
          done <= 1'b1;
`else
          if (rej_q) err  <= 1'b1;
          else       done <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

`ifdef FB_RECT_FILL_CLIP_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fb_rect_fill.sv
`timescale 1ns/1ps
module tb_fb_rect_fill;
  localparam int W = 280;
  localparam int H = 192;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [8:0]  cmd_x = '0;
  logic [7:0]  cmd_y = '0;
  logic [8:0]  cmd_w = '0;
  logic [7:0]  cmd_h = '0;
  logic [23:0] cmd_color = '0;
  logic        stall = 1'b0;
  logic        busy, done, err;
  logic [23:0] fb_d;
  logic [15:0] fb_adr_w;
  logic        fb_we, fb_w_clk;

  fb_rect_fill dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .stall(stall), .busy(busy), .done(done), .err(err), .fb_d(fb_d),
    .fb_adr_w(fb_adr_w), .fb_we(fb_we), .fb_w_clk(fb_w_clk)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_bad = 0;

  // Observation state, cleared at each handshake.
  int          cyc = 0;
  logic        stall_prev = 1'b0;
  logic        stall_en = 1'b0;
  logic [39:0] got_q[$];
  int          exp_q[$];
  int          nwr = 0, first_we_cyc = 0, last_we_cyc = 0;
  int          done_cnt = 0, done_cyc = 0, err_cnt = 0;
  int          both_viol = 0, stall_viol = 0;

  always @(posedge CLOCK_50) begin
    cyc++;
    stall_prev = stall;
  end

  always @(negedge CLOCK_50) begin
    if (fb_we) begin
      got_q.push_back({fb_adr_w, fb_d});
      if (nwr == 0) first_we_cyc = cyc;
      last_we_cyc = cyc;
      nwr++;
      if (stall_prev) stall_viol++;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) err_cnt++;
    if (done && err) both_viol++;
  end

  initial begin
    forever begin
      @(negedge CLOCK_50);
      stall = stall_en ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
  end

  // Reference: every on-screen pixel of the rectangle in raster order, unless
  // the command is rejected for sticking out of the screen.
  task automatic model(input int x, input int y, input int w, input int h, output bit e_err);
    bit area, rej;
    exp_q.delete();
    area = (w > 0) && (h > 0) && (x < W) && (y < H);
`ifdef FB_RECT_FILL_CLIP_EN
    rej = 1'b0;
`else
    rej = area && ((x + w > W) || (y + h > H));
`endif
    e_err = rej;
    if (area && !rej)
      for (int r = y; r < y + h && r < H; r++)
        for (int c = x; c < x + w && c < W; c++)
          exp_q.push_back(r * W + c);
  endtask

  function automatic int first_diff(input logic [23:0] color);
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (got_q[i] !== {16'(exp_q[i]), color}) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic send_cmd(input int x, input int y, input int w, input int h,
                          input logic [23:0] color, output int hs_cyc, output bit to);
    int n;
    n = 0;
    @(negedge CLOCK_50);
    while (!cmd_ready && n < 50) begin @(negedge CLOCK_50); n++; end
    to = !cmd_ready;
    cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h); cmd_color = color;
    cmd_valid = 1'b1;
    hs_cyc = cyc;
    got_q.delete();
    nwr = 0; done_cnt = 0; err_cnt = 0; both_viol = 0; stall_viol = 0;
    @(negedge CLOCK_50);
    cmd_valid = 1'b0;
  endtask

  // Waits for done/err while waving a garbage command that must be ignored.
  task automatic wait_finish(input int budget, output bit to);
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge CLOCK_50);
      n++;
      seen = done || err;
      if (!seen) begin
        cmd_valid = 1'b1;
        cmd_x = 9'($urandom); cmd_y = 8'($urandom); cmd_w = 9'($urandom); cmd_h = 8'($urandom);
        cmd_color = 24'($urandom);
      end
    end
    cmd_valid = 1'b0;
    to = !seen;
    repeat (3) @(negedge CLOCK_50);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #23;
    n_cmp++;
    if ({cmd_ready, busy, done, err, fb_we} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {cmd_ready, busy, done, err, fb_we});
    end
    n_cmp++;
    if (fb_adr_w !== 16'h0) begin n_bad++; $display("FAIL reset_adr: got %h want 0", fb_adr_w); end
    n_cmp++;
    if (fb_d !== 24'h0) begin n_bad++; $display("FAIL reset_dat: got %h want 0", fb_d); end
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(posedge CLOCK_50); #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_full_screen;
    int hs, idx; bit to, e_err;
    model(0, 0, W, H, e_err);
    send_cmd(0, 0, W, H, 24'hFF0000, hs, to);
    wait_finish(60000, to);
    idx = first_diff(24'hFF0000);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL full_timeout: done not seen within budget"); end
    n_cmp++;
    if (nwr !== exp_q.size()) begin n_bad++; $display("FAIL full_count: got %0d want %0d", nwr, exp_q.size()); end
    n_cmp++;
    if (idx != -1) begin n_bad++; $display("FAIL full_seq: first bad write index %0d", idx); end
    n_cmp++;
    if (done_cnt !== 1 || err_cnt !== 0) begin
      n_bad++; $display("FAIL full_done: got done=%0d err=%0d want 1/0", done_cnt, err_cnt);
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL full_busy: got %b want 0", busy); end
  endtask

  task automatic test_small_timing;
    int hs, idx; bit to, e_err;
    stall_en = 1'b0;
    model(10, 5, 3, 2, e_err);
    send_cmd(10, 5, 3, 2, 24'h00FF00, hs, to);
    wait_finish(100, to);
    idx = first_diff(24'h00FF00);
    n_cmp++;
    if (to || idx != -1) begin n_bad++; $display("FAIL small_seq: timeout=%0d first bad index %0d", to, idx); end
    n_cmp++;
    if (first_we_cyc !== hs + 3) begin
      n_bad++; $display("FAIL small_first_we: got cycle %0d want %0d", first_we_cyc, hs + 3);
    end
    n_cmp++;
    if (done_cyc !== last_we_cyc + 1) begin
      n_bad++; $display("FAIL small_done_lat: got cycle %0d want %0d", done_cyc, last_we_cyc + 1);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL small_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_stall;
    int hs, idx, x, y, w, h; bit to, e_err; logic [23:0] col;
    stall_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      x = (k == 0) ? 10 : $urandom_range(0, 260);
      y = (k == 0) ? 5 : $urandom_range(0, 180);
      w = (k == 0) ? 3 : $urandom_range(1, 12);
      h = (k == 0) ? 2 : $urandom_range(1, 8);
      col = 24'($urandom);
      model(x, y, w, h, e_err);
      send_cmd(x, y, w, h, col, hs, to);
      wait_finish(2000, to);
      idx = first_diff(col);
      n_cmp++;
      if (to || idx != -1) begin
        n_bad++; $display("FAIL stall_seq[%0d]: timeout=%0d first bad index %0d writes %0d want %0d",
                          k, to, idx, nwr, exp_q.size());
      end
      n_cmp++;
      if (stall_viol !== 0) begin n_bad++; $display("FAIL stall_we[%0d]: got %0d writes under stall want 0", k, stall_viol); end
    end
    stall_en = 1'b0;
  endtask

  task automatic test_corner;
    int hs, idx; bit to, e_err;
    model(278, 190, 5, 5, e_err);
    send_cmd(278, 190, 5, 5, 24'h123456, hs, to);
    wait_finish(100, to);
    idx = first_diff(24'h123456);
    n_cmp++;
    if (to || idx != -1) begin n_bad++; $display("FAIL corner_seq: timeout=%0d first bad index %0d writes %0d", to, idx, nwr); end
    n_cmp++;
    if (done_cnt !== (e_err ? 0 : 1) || err_cnt !== (e_err ? 1 : 0)) begin
      n_bad++; $display("FAIL corner_status: got done=%0d err=%0d want %0d/%0d",
                        done_cnt, err_cnt, e_err ? 0 : 1, e_err ? 1 : 0);
    end
  endtask

  task automatic test_zero_area;
    int hs, n, x, y, w, h; bit to;
    for (int k = 0; k < 3; k++) begin
      x = (k == 2) ? 300 : $urandom_range(0, 279);
      y = $urandom_range(0, 191);
      w = (k == 0) ? 0 : 4;
      h = (k == 1) ? 0 : 3;
      send_cmd(x, y, w, h, 24'hABCDEF, hs, to);
      n = 0;
      while (!cmd_ready && n < 10) begin @(negedge CLOCK_50); n++; end
      n_cmp++;
      if (!cmd_ready || cyc > hs + 4) begin
        n_bad++; $display("FAIL zero_ready[%0d]: ready=%b at cycle %0d want by %0d", k, cmd_ready, cyc, hs + 4);
      end
      n_cmp++;
      if (nwr !== 0 || done_cnt !== 1 || err_cnt !== 0) begin
        n_bad++; $display("FAIL zero_result[%0d]: got writes=%0d done=%0d err=%0d want 0/1/0", k, nwr, done_cnt, err_cnt);
      end
    end
  endtask

  task automatic test_random;
    int hs, idx, x, y, w, h; bit to, e_err; logic [23:0] col;
    for (int k = 0; k < 20; k++) begin
      x = $urandom_range(0, 290); y = $urandom_range(0, 200);
      w = $urandom_range(0, 24);  h = $urandom_range(0, 12);
      col = 24'($urandom);
      stall_en = $urandom_range(0, 1) == 1;
      model(x, y, w, h, e_err);
      send_cmd(x, y, w, h, col, hs, to);
      wait_finish(2000, to);
      idx = first_diff(col);
      n_cmp++;
      if (to || idx != -1) begin
        n_bad++; $display("FAIL rand_seq[%0d] (%0d,%0d,%0d,%0d): timeout=%0d first bad %0d writes %0d want %0d",
                          k, x, y, w, h, to, idx, nwr, exp_q.size());
      end
      n_cmp++;
      if (done_cnt !== (e_err ? 0 : 1) || err_cnt !== (e_err ? 1 : 0) || both_viol !== 0) begin
        n_bad++; $display("FAIL rand_status[%0d]: got done=%0d err=%0d both=%0d want %0d/%0d/0",
                          k, done_cnt, err_cnt, both_viol, e_err ? 0 : 1, e_err ? 1 : 0);
      end
    end
    stall_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    int hs, idx; bit to, e_err;
    stall_en = 1'b0;
    send_cmd(0, 0, 100, 100, 24'h0000FF, hs, to);
    repeat (300) @(posedge CLOCK_50);
    #1;
    n_cmp++;
    if (fb_we !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL mid_active: got we=%b busy=%b want 1/1", fb_we, busy); end
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if ({fb_we, busy, done} !== 3'b000) begin n_bad++; $display("FAIL mid_async: got %b want 000", {fb_we, busy, done}); end
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b1;
    @(posedge CLOCK_50); #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || done_cnt !== 0) begin
      n_bad++; $display("FAIL mid_recover: got ready=%b done=%0d want 1/0", cmd_ready, done_cnt);
    end
    model(0, 0, 1, 1, e_err);
    send_cmd(0, 0, 1, 1, 24'h777777, hs, to);
    wait_finish(100, to);
    idx = first_diff(24'h777777);
    n_cmp++;
    if (to || idx != -1 || done_cnt !== 1) begin
      n_bad++; $display("FAIL mid_1x1: timeout=%0d first bad %0d writes %0d done %0d want 1 write, 1 done", to, idx, nwr, done_cnt);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_small_timing();
    test_stall();
    test_corner();
    test_zero_area();
    test_random();
    test_reset_mid();
    test_full_screen();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
